// File: rtl/accel_pkg.sv
// Shared accelerator definitions: opcode constants, instruction-format width
// derivations and the issuer state encoding.
package accel_pkg;

    localparam logic [3:0] OPC_NOP  = 4'h0;
    localparam logic [3:0] OPC_WAIT = 4'hF;

    // Opcode occupies the top OPC_W bits of every instruction word.
    localparam int OPC_W = 4;

    function automatic int calcInsW(input int depth);
        return (2 > depth) ? 2 : depth;
    endfunction

    function automatic int calcInsD(input int depth, input int w);
        return ((1 << depth) > w) ? (1 << depth) : w;
    endfunction

    function automatic int calcInsWidth(input int depth, input int w);
        return OPC_W + 2 + 2 * calcInsW(depth) + calcInsD(depth, w);
    endfunction

    typedef enum logic {
        ST_ISSUE = 1'b0,
        ST_WAIT  = 1'b1
    } issueState_t;

endpackage

// File: rtl/instr_fifo.sv
// Synchronous show-ahead FIFO for instruction words: head is readable
// combinationally, occupancy is kept in a registered count.
module instr_fifo #(
    parameter int DW = 28,
    parameter int AW = 4
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          wrEn,
    input  logic [DW-1:0] wrData,
    input  logic          rdEn,
    output logic [DW-1:0] rdData,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    localparam logic [AW:0] ENTRIES = (AW+1)'(1 << AW);

    logic [DW-1:0] memArr [2**AW];
    logic [AW-1:0] wrPtrReg, rdPtrReg;
    logic [AW:0]   countReg;
    logic          wrAccept, rdAccept;

    assign full     = (countReg == ENTRIES);
    assign empty    = (countReg == '0);
    assign count    = countReg;
    assign wrAccept = wrEn && !full;
    assign rdAccept = rdEn && !empty;
    assign rdData   = memArr[rdPtrReg];

    always_ff @(posedge CLK) begin
        if (wrAccept) begin
            memArr[wrPtrReg] <= wrData;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wrPtrReg <= '0;
            rdPtrReg <= '0;
            countReg <= '0;
        end else begin
            if (wrAccept) wrPtrReg <= wrPtrReg + 1'b1;
            if (rdAccept) rdPtrReg <= rdPtrReg + 1'b1;
            case ({wrAccept, rdAccept})
                2'b10:   countReg <= countReg + 1'b1;
                2'b01:   countReg <= countReg - 1'b1;
                default: countReg <= countReg;
            endcase
        end
    end

endmodule

// File: rtl/instruction_issuer.sv
// Feeds the accelerator one instruction per cycle from a host FIFO, expanding
// WAIT into NOP stretches. Result capture is enabled by INSTRUCTION_ISSUER_RESULT_CAPTURE_EN.
module instruction_issuer
    import accel_pkg::*;
#(
    parameter int         depth    = 3,
    parameter int         W        = 16,
    parameter int         FIFO_AW  = 4,
    parameter logic [3:0] READ_OP  = 4'h2,
    parameter int         READ_LAT = 2,
    localparam int        insW     = calcInsW(depth),
    localparam int        insD     = calcInsD(depth, W),
    localparam int        insWidth = calcInsWidth(depth, W)
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [insWidth-1:0] in_data,
    input  logic                halt,
    output logic [insWidth-1:0] instruction,
    input  logic [W-1:0]        dataOut,
    output logic                busy,
    output logic [15:0]         issued_count
`ifdef INSTRUCTION_ISSUER_RESULT_CAPTURE_EN
    ,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [W-1:0]        res_data
`endif
);

    issueState_t         stateReg, stateNext;
    logic [insD-1:0]     waitCntReg, waitCntNext;
    logic [insWidth-1:0] instrReg, instrNext;
    logic [15:0]         issuedCntReg, issuedCntNext;
    logic                busyReg, busyNext;

    logic [insWidth-1:0] fifoHead;
    logic                fifoFull, fifoEmpty;
    logic [FIFO_AW:0]    fifoCount, occNext;
    logic                pushAcc, pop;
    logic [OPC_W-1:0]    headOpc;
    logic                captureStall, captureBusyNext;

    assign in_ready = !fifoFull && !RST;
    assign pushAcc  = in_valid && in_ready;
    assign headOpc  = fifoHead[insWidth-1 -: OPC_W];

    instr_fifo #(
        .DW (insWidth),
        .AW (FIFO_AW)
    ) uFifo (
        .CLK    (CLK),
        .RST    (RST),
        .wrEn   (pushAcc),
        .wrData (in_data),
        .rdEn   (pop),
        .rdData (fifoHead),
        .full   (fifoFull),
        .empty  (fifoEmpty),
        .count  (fifoCount)
    );

    always_comb begin
        stateNext     = stateReg;
        waitCntNext   = waitCntReg;
        instrNext     = '0;
        issuedCntNext = issuedCntReg;
        pop           = 1'b0;
        case (stateReg)
            ST_ISSUE: begin
                if (!halt && !fifoEmpty && !captureStall) begin
                    pop = 1'b1;
                    if (headOpc == OPC_WAIT) begin
                        waitCntNext = fifoHead[insD-1:0];
                        if (fifoHead[insD-1:0] != '0) stateNext = ST_WAIT;
                    end else begin
                        instrNext = fifoHead;
                        if (headOpc != OPC_NOP) issuedCntNext = issuedCntReg + 16'd1;
                    end
                end
            end
            ST_WAIT: begin
                // halt does not freeze the stretch; it only gates popping.
                waitCntNext = waitCntReg - 1'b1;
                if (waitCntReg <= insD'(1)) stateNext = ST_ISSUE;
            end
            default: stateNext = ST_ISSUE;
        endcase
    end

    assign occNext  = fifoCount + (FIFO_AW+1)'(pushAcc) - (FIFO_AW+1)'(pop);
    assign busyNext = (occNext != '0) || (stateNext == ST_WAIT) || captureBusyNext;

    always_ff @(posedge CLK) begin
        if (RST) begin
            stateReg     <= ST_ISSUE;
            waitCntReg   <= '0;
            instrReg     <= '0;
            issuedCntReg <= '0;
            busyReg      <= 1'b0;
        end else begin
            stateReg     <= stateNext;
            waitCntReg   <= waitCntNext;
            instrReg     <= instrNext;
            issuedCntReg <= issuedCntNext;
            busyReg      <= busyNext;
        end
    end

    assign instruction  = instrReg;
    assign busy         = busyReg;
    assign issued_count = issuedCntReg;

`ifdef INSTRUCTION_ISSUER_RESULT_CAPTURE_EN
    logic [READ_LAT-1:0] pipeReg, pipeNext;
    logic                resValidReg;
    logic [W-1:0]        resDataReg;
    logic                instrIsRead, nextIsRead;

    assign instrIsRead = (instrReg[insWidth-1 -: OPC_W] == READ_OP);
    assign nextIsRead  = (instrNext[insWidth-1 -: OPC_W] == READ_OP);

    // Stage 0 loads the cycle after READ_OP is on the bus, so the last stage
    // lines up with the accelerator presenting dataOut.
    assign pipeNext[0] = instrIsRead;
    for (genvar gi = 1; gi < READ_LAT; gi++) begin : gCapStage
        assign pipeNext[gi] = pipeReg[gi-1];
    end

    assign captureStall    = (headOpc == READ_OP) && (resValidReg || instrIsRead || (|pipeReg));
    assign captureBusyNext = nextIsRead || (|pipeNext);

    always_ff @(posedge CLK) begin
        if (RST) begin
            pipeReg     <= '0;
            resValidReg <= 1'b0;
            resDataReg  <= '0;
        end else begin
            pipeReg <= pipeNext;
            if (pipeReg[READ_LAT-1]) begin
                resValidReg <= 1'b1;
                resDataReg  <= dataOut;
            end else if (resValidReg && res_ready) begin
                resValidReg <= 1'b0;
            end
        end
    end

    assign res_valid = resValidReg;
    assign res_data  = resDataReg;
`else
    logic unusedBits;

    assign captureStall    = 1'b0;
    assign captureBusyNext = 1'b0;
    assign unusedBits      = ^{dataOut, READ_OP, 32'(READ_LAT)};
`endif

endmodule

// File: tb/tb_instruction_issuer.sv
// Directed + random bench for instruction_issuer; a queue holds the words
// expected on the instruction bus and a negedge monitor consumes them.
module tb_instruction_issuer;
    import accel_pkg::*;

    localparam int INSW = calcInsWidth(3, 16);

    logic            CLK = 1'b0;
    logic            RST;
    logic            in_valid;
    logic            in_ready;
    logic [INSW-1:0] in_data;
    logic            halt;
    logic [INSW-1:0] instruction;
    logic [15:0]     dataOut;
    logic            busy;
    logic [15:0]     issued_count;
`ifdef INSTRUCTION_ISSUER_RESULT_CAPTURE_EN
    logic            res_valid;
    logic            res_ready;
    logic [15:0]     res_data;
`endif

    instruction_issuer dut (
        .CLK          (CLK),
        .RST          (RST),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .halt         (halt),
        .instruction  (instruction),
        .dataOut      (dataOut),
        .busy         (busy),
        .issued_count (issued_count)
`ifdef INSTRUCTION_ISSUER_RESULT_CAPTURE_EN
        ,
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_data     (res_data)
`endif
    );

    always #5 CLK = ~CLK;

    int              passCnt = 0;
    int              totalCnt = 0;
    logic [INSW-1:0] expQ[$];
    int unsigned     expIssued;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        totalCnt++;
        assert (got === exp) passCnt++;
        else $error("FAIL %s: observed %h expected %h", tag, got, exp);
    endtask

    function automatic logic [INSW-1:0] mk(input logic [3:0] op, input logic [23:0] pl);
        return {op, pl};
    endfunction

    // Every non-NOP word on the bus must be the next one the host pushed.
    always @(negedge CLK) begin
        if (!RST && instruction !== '0) begin
            if (expQ.size() == 0) check("unexpected_issue", 32'(instruction), 32'd0);
            else                  check("issue_order", 32'(instruction), 32'(expQ.pop_front()));
            $display("issue %h", instruction);
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic pushOne(input logic [INSW-1:0] w);
        int n = 0;
        in_valid = 1'b1;
        in_data  = w;
        while (!in_ready && n < 200) begin
            @(posedge CLK); #1;
            n++;
        end
        if (n >= 200) check("push_timeout", 32'(in_ready), 32'd1);
        @(posedge CLK); #1;
        in_valid = 1'b0;
        if (w[INSW-1 -: 4] != OPC_WAIT) expQ.push_back(w);
        $display("push %h", w);
    endtask

    initial begin
        logic [INSW-1:0] w1, w3, w5, w7, w9, extra;
        int              n;
        bit              found;
        int              nonZero;
        logic [3:0]      op;
        logic [INSW-1:0] d;

        RST = 1'b1; in_valid = 1'b1; in_data = mk(4'h1, 24'h0); halt = 1'b0; dataOut = '0;
`ifdef INSTRUCTION_ISSUER_RESULT_CAPTURE_EN
        res_ready = 1'b0;
`endif
        // Reset state, with a valid host word offered to prove in_ready is gated.
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_instruction", 32'(instruction), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_issued_count", 32'(issued_count), 32'd0);
        RST = 1'b0; in_valid = 1'b0;
        #1 check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Back-to-back 1,3,5: first word appears after the second edge.
        w1 = mk(4'h1, 24'h000011); w3 = mk(4'h3, 24'h000033); w5 = mk(4'h5, 24'h000055);
        @(posedge CLK); #1;
        in_valid = 1'b1; in_data = w1; expQ.push_back(w1);
        @(posedge CLK); #1; in_data = w3; expQ.push_back(w3);
        @(posedge CLK); #1; in_data = w5; expQ.push_back(w5);
        @(negedge CLK); check("lat_w1", 32'(instruction), 32'(w1));
        @(posedge CLK); #1; in_valid = 1'b0;
        @(negedge CLK); check("lat_w3", 32'(instruction), 32'(w3));
        @(negedge CLK); check("lat_w5", 32'(instruction), 32'(w5));
        @(negedge CLK); check("lat_idle", 32'(instruction), 32'd0);
        check("count_3", 32'(issued_count), 32'd3);

        // Fill to 16 under halt; the 17th word must be refused.
        @(posedge CLK); #1;
        halt = 1'b1;
        for (int i = 0; i < 16; i++) pushOne(mk(4'(3 + i % 12), 24'(i + 24'h100)));
        extra = mk(4'h4, 24'hBAD);
        in_valid = 1'b1; in_data = extra;
        #1 check("full_in_ready", 32'(in_ready), 32'd0);
        @(posedge CLK); #1;
        check("full_in_ready_hold", 32'(in_ready), 32'd0);
        check("full_busy", 32'(busy), 32'd1);
        in_valid = 1'b0;
        halt = 1'b0;
        @(posedge CLK);
        for (int i = 0; i < 16; i++) begin
            @(negedge CLK);
            check("drain_no_gap", 32'(instruction), 32'(mk(4'(3 + i % 12), 24'(i + 24'h100))));
        end
        @(negedge CLK); check("drain_idle", 32'(instruction), 32'd0);
        check("count_19", 32'(issued_count), 32'd19);

        // WAIT 3 then 7: four NOP cycles before 7.
        @(posedge CLK); #1;
        w7 = mk(4'h7, 24'h000777);
        pushOne(mk(OPC_WAIT, 24'd3));
        pushOne(w7);
        n = 0; found = 1'b0;
        for (int k = 0; k < 50 && !found; k++) begin
            @(negedge CLK);
            if (k == 1) check("wait_busy", 32'(busy), 32'd1);
            if (instruction == '0) n++; else found = 1'b1;
        end
        check("wait3_nops", 32'(n), 32'd4);
        check("after_wait3", 32'(instruction), 32'(w7));

        // WAIT 0 then 9: a single NOP cycle.
        @(posedge CLK); #1;
        w9 = mk(4'h9, 24'h000999);
        pushOne(mk(OPC_WAIT, 24'd0));
        pushOne(w9);
        n = 0; found = 1'b0;
        for (int k = 0; k < 50 && !found; k++) begin
            @(negedge CLK);
            if (instruction == '0) n++; else found = 1'b1;
        end
        check("wait0_nops", 32'(n), 32'd1);
        check("after_wait0", 32'(instruction), 32'(w9));
        check("count_21", 32'(issued_count), 32'd21);

`ifdef INSTRUCTION_ISSUER_RESULT_CAPTURE_EN
        // Two READs: capture the first, keep the second stalled until res_ready.
        @(posedge CLK); #1;
        pushOne(mk(4'h2, 24'h000001));
        pushOne(mk(4'h2, 24'h000002));
        @(posedge CLK); @(posedge CLK); #1;
        dataOut = 16'hA5A5;
        @(posedge CLK); #1;
        dataOut = 16'h0000;
        @(negedge CLK);
        check("cap_valid", 32'(res_valid), 32'd1);
        check("cap_data", 32'(res_data), 32'h0000A5A5);
        check("cap_stall", 32'(instruction), 32'd0);
        repeat (2) @(negedge CLK);
        check("cap_stall_hold", 32'(instruction), 32'd0);
        @(posedge CLK); #1; res_ready = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        check("cap_cleared", 32'(res_valid), 32'd0);
        check("cap_not_yet", 32'(instruction), 32'd0);
        @(negedge CLK);
        check("cap_second_read", 32'(instruction), 32'(mk(4'h2, 24'h000002)));
        repeat (10) @(negedge CLK);
`endif

        // Reset in the middle of WAIT 10 with five words queued behind it.
        @(posedge CLK); #1;
        halt = 1'b1;
        pushOne(mk(OPC_WAIT, 24'd10));
        for (int i = 0; i < 5; i++) pushOne(mk(4'h6, 24'(i + 24'h600)));
        halt = 1'b0;
        repeat (4) @(posedge CLK);
        #1;
        RST = 1'b1; in_valid = 1'b1; in_data = mk(4'h8, 24'h888);
        expQ.delete();
        @(posedge CLK);
        @(negedge CLK);
        check("abort_instruction", 32'(instruction), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_count", 32'(issued_count), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd0);
        RST = 1'b0; in_valid = 1'b0;
        nonZero = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK);
            if (instruction != '0) nonZero++;
        end
        check("abort_no_leftover", 32'(nonZero), 32'd0);
        check("abort_idle_busy", 32'(busy), 32'd0);
        check("abort_fifo_empty", 32'(in_ready), 32'd1);

        // Random push/halt traffic against the queue model.
        expIssued = 0;
        @(posedge CLK); #1;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            op = 4'($urandom_range(1, 15));
            d  = {op, 24'($urandom)};
            if (op == OPC_WAIT) d[15:0] = 16'($urandom_range(0, 3));
            in_valid = 1'($urandom_range(0, 1));
            halt     = ($urandom_range(0, 3) == 0);
            in_data  = d;
            if (in_valid && in_ready && op != OPC_WAIT) begin
                expQ.push_back(d);
                expIssued++;
            end
            @(posedge CLK); #1;
        end
        in_valid = 1'b0; halt = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 3000 && !found; k++) begin
            @(negedge CLK);
            if (!busy) found = 1'b1;
        end
        check("rand_drain_done", 32'(found), 32'd1);
        repeat (3) @(negedge CLK);
        check("rand_queue_empty", 32'(expQ.size()), 32'd0);
        check("rand_issued_count", 32'(issued_count), 32'(expIssued[15:0]));

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
